// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Opcodes, FSM states, datapath mux selects and ALU-control function codes.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_WB_LOAD  = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EX_R     = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ANDI_EX  = 4'd12;
  localparam logic [3:0] S_ADDI_WB  = 4'd13;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  function automatic logic op_known(input logic [5:0] op);
    logic k;
    k = 1'b0;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_JAL, OP_ADDI, OP_ANDI: k = 1'b1;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Control-output decoder for the multicycle main controller.
// Moore outputs from state; memReady gates IF strobes, jr gates EX_R PC write.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       jr_i,
  input  logic       mem_ready_i,
  output logic       pcWrite_o,
  output logic       pcWriteCond_o,
  output logic       branchNe_o,
  output logic       iorD_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       irWrite_o,
  output logic       regWrite_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [1:0] pcSrc_o,
  output logic [1:0] memToReg_o,
  output logic [1:0] regDst_o,
  output logic       aluOp_o,
  output logic       aluAdd_o,
  output logic       aluSub_o,
  output logic       aluAnd_o,
  output logic       illegal_o
);

  // Per-state control word; anything not set stays low.
  always_comb begin
    pcWrite_o     = 1'b0;
    pcWriteCond_o = 1'b0;
    branchNe_o    = 1'b0;
    iorD_o        = 1'b0;
    memRead_o     = 1'b0;
    memWrite_o    = 1'b0;
    irWrite_o     = 1'b0;
    regWrite_o    = 1'b0;
    aluSrcA_o     = 1'b0;
    aluSrcB_o     = SRCB_B;
    pcSrc_o       = PCSRC_ALU;
    memToReg_o    = M2R_ALUOUT;
    regDst_o      = RDST_RT;
    aluOp_o       = 1'b0;
    aluAdd_o      = 1'b0;
    aluSub_o      = 1'b0;
    aluAnd_o      = 1'b0;
    illegal_o     = 1'b0;
    case (state_i)
      S_IF: begin
        memRead_o = 1'b1;
        aluSrcB_o = SRCB_FOUR;
        aluAdd_o  = 1'b1;
        irWrite_o = mem_ready_i;
        pcWrite_o = mem_ready_i;
      end
      S_ID: begin
        aluSrcB_o = SRCB_IMM_SH;
        aluAdd_o  = 1'b1;
        illegal_o = ~op_known(opcode_i);
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        aluSrcA_o = 1'b1;
        aluSrcB_o = SRCB_IMM;
        aluAdd_o  = 1'b1;
      end
      S_ANDI_EX: begin
        aluSrcA_o = 1'b1;
        aluSrcB_o = SRCB_IMM;
        aluAnd_o  = 1'b1;
      end
      S_MEM_RD: begin
        memRead_o = 1'b1;
        iorD_o    = 1'b1;
      end
      S_WB_LOAD: begin
        regWrite_o = 1'b1;
        memToReg_o = M2R_MDR;
      end
      S_MEM_WR: begin
        memWrite_o = 1'b1;
        iorD_o     = 1'b1;
      end
      S_EX_R: begin
        aluSrcA_o = 1'b1;
        aluOp_o   = 1'b1;
        pcWrite_o = jr_i;
        pcSrc_o   = jr_i ? PCSRC_RS : PCSRC_ALU;
      end
      S_WB_R: begin
        regWrite_o = 1'b1;
        regDst_o   = RDST_RD;
      end
      S_BRANCH: begin
        aluSrcA_o     = 1'b1;
        aluSub_o      = 1'b1;
        pcWriteCond_o = 1'b1;
        pcSrc_o       = PCSRC_ALUOUT;
        branchNe_o    = (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        pcWrite_o = 1'b1;
        pcSrc_o   = PCSRC_JUMP;
      end
      S_JAL: begin
        pcWrite_o  = 1'b1;
        pcSrc_o    = PCSRC_JUMP;
        regWrite_o = 1'b1;
        regDst_o   = RDST_RA;
        memToReg_o = M2R_PC;
      end
      S_ADDI_WB: begin
        regWrite_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM.
// Holds the state register and next-state logic; outputs come from mc_ctrl_decode.
module mc_main_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [1:0] memToReg,
  output logic [1:0] regDst,
  output logic       aluOp,
  output logic       aluAdd,
  output logic       aluSub,
  output logic       aluAnd,
  output logic       illegal
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ready_gated;

  // While in reset the fetch strobes must stay low even if memory answers.
  assign ready_gated = memReady & rst;

  // Next-state sequencing through the instruction phases.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:       state_d = memReady ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_EX_R;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          OP_ADDI:         state_d = S_ADDI_EX;
          OP_ANDI:         state_d = S_ANDI_EX;
          default:         state_d = S_IF;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = memReady ? S_WB_LOAD : S_MEM_RD;
      S_MEM_WR:   state_d = memReady ? S_IF : S_MEM_WR;
      S_EX_R:     state_d = jr ? S_IF : S_WB_R;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ANDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_IF;
    endcase
  end

  // State register; reset abandons any partial instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  mc_ctrl_decode u_dec (
    .state_i       (state_q),
    .opcode_i      (opcode),
    .jr_i          (jr),
    .mem_ready_i   (ready_gated),
    .pcWrite_o     (pcWrite),
    .pcWriteCond_o (pcWriteCond),
    .branchNe_o    (branchNe),
    .iorD_o        (iorD),
    .memRead_o     (memRead),
    .memWrite_o    (memWrite),
    .irWrite_o     (irWrite),
    .regWrite_o    (regWrite),
    .aluSrcA_o     (aluSrcA),
    .aluSrcB_o     (aluSrcB),
    .pcSrc_o       (pcSrc),
    .memToReg_o    (memToReg),
    .regDst_o      (regDst),
    .aluOp_o       (aluOp),
    .aluAdd_o      (aluAdd),
    .aluSub_o      (aluSub),
    .aluAnd_o      (aluAnd),
    .illegal_o     (illegal)
  );

endmodule

// File: tb/tb_mc_main_controller.sv
// Self-checking bench for mc_main_controller.
// Table of cycle counts, hand sequences, and random instructions vs a per-instruction model.
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       jr;
  logic       memReady;
  logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite;
  logic       irWrite, regWrite, aluSrcA;
  logic [1:0] aluSrcB, pcSrc, memToReg, regDst;
  logic       aluOp, aluAdd, aluSub, aluAnd, illegal;

  mc_main_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .jr(jr), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .memToReg(memToReg), .regDst(regDst),
    .aluOp(aluOp), .aluAdd(aluAdd), .aluSub(aluSub), .aluAnd(aluAnd),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite;
    logic       irWrite, regWrite, aluSrcA;
    logic [1:0] aluSrcB, pcSrc, memToReg, regDst;
    logic       aluOp, aluAdd, aluSub, aluAnd, illegal;
  } ctl_t;

  ctl_t act;
  assign act = {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite,
                irWrite, regWrite, aluSrcA, aluSrcB, pcSrc, memToReg,
                regDst, aluOp, aluAdd, aluSub, aluAnd, illegal};

  typedef struct {
    logic mr;
    logic jv;
    ctl_t exp;
  } step_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic       jv;
    int         cyc;
    logic       wreg;
    logic       wmem;
  } vec_t;

  step_t plan[$];
  vec_t  tbl[11];
  int    checks = 0;
  int    errors = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011, ADDI = 6'b001000, ANDI = 6'b001100;

  function automatic logic legal(input logic [5:0] op);
    return op inside {R, LW, SW, BEQ, BNE, J, JAL, ADDI, ANDI};
  endfunction

  function automatic ctl_t fetch_ctl(input logic done);
    ctl_t c;
    c = '0;
    c.memRead = 1'b1;
    c.aluSrcB = 2'b01;
    c.aluAdd  = 1'b1;
    c.irWrite = done;
    c.pcWrite = done;
    return c;
  endfunction

  task automatic chk_ctl(input string nm, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: lists every cycle's inputs and expected controls.
  task automatic build(input logic [5:0] op, input logic jv,
                       input int fs, input int ms);
    ctl_t c;
    plan.delete();
    for (int k = 0; k < fs; k++) plan.push_back('{1'b0, rb(), fetch_ctl(1'b0)});
    plan.push_back('{1'b1, rb(), fetch_ctl(1'b1)});
    c = '0;
    c.aluSrcB = 2'b11;
    c.aluAdd  = 1'b1;
    c.illegal = !legal(op);
    plan.push_back('{rb(), rb(), c});
    if (op == LW || op == SW) begin
      c = '0;
      c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluAdd = 1'b1;
      plan.push_back('{rb(), rb(), c});
      c = '0;
      c.iorD = 1'b1;
      if (op == LW) c.memRead = 1'b1;
      else          c.memWrite = 1'b1;
      for (int k = 0; k < ms; k++) plan.push_back('{1'b0, rb(), c});
      plan.push_back('{1'b1, rb(), c});
      if (op == LW) begin
        c = '0;
        c.regWrite = 1'b1; c.memToReg = 2'b01;
        plan.push_back('{rb(), rb(), c});
      end
    end else if (op == R) begin
      c = '0;
      c.aluSrcA = 1'b1; c.aluOp = 1'b1;
      if (jv) begin c.pcWrite = 1'b1; c.pcSrc = 2'b11; end
      plan.push_back('{rb(), jv, c});
      if (!jv) begin
        c = '0;
        c.regWrite = 1'b1; c.regDst = 2'b01;
        plan.push_back('{rb(), rb(), c});
      end
    end else if (op == BEQ || op == BNE) begin
      c = '0;
      c.aluSrcA = 1'b1; c.aluSub = 1'b1; c.pcWriteCond = 1'b1;
      c.pcSrc = 2'b01; c.branchNe = (op == BNE);
      plan.push_back('{rb(), rb(), c});
    end else if (op == J || op == JAL) begin
      c = '0;
      c.pcWrite = 1'b1; c.pcSrc = 2'b10;
      if (op == JAL) begin
        c.regWrite = 1'b1; c.regDst = 2'b10; c.memToReg = 2'b10;
      end
      plan.push_back('{rb(), rb(), c});
    end else if (op == ADDI || op == ANDI) begin
      c = '0;
      c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
      if (op == ADDI) c.aluAdd = 1'b1;
      else            c.aluAnd = 1'b1;
      plan.push_back('{rb(), rb(), c});
      c = '0;
      c.regWrite = 1'b1;
      plan.push_back('{rb(), rb(), c});
    end
  endtask

  // Applies the plan cycle by cycle, then confirms the FSM is back in fetch.
  task automatic run_plan(input string tag, input logic [5:0] op,
                          output int mw_cycles);
    mw_cycles = 0;
    opcode = op;
    foreach (plan[i]) begin
      memReady = plan[i].mr;
      jr       = plan[i].jv;
      @(negedge clk);
      chk_ctl($sformatf("%s c%0d", tag, i), act, plan[i].exp);
      if (memWrite && regWrite) chk_int({tag, " wr_excl"}, 1, 0);
      if (memWrite) mw_cycles++;
      @(posedge clk); #1;
    end
    memReady = 1'b0;
    jr = 1'b0;
    @(negedge clk);
    chk_ctl({tag, " back_to_IF"}, act, fetch_ctl(1'b0));
    @(posedge clk); #1;
  endtask

  // Counts cycles until fetch is seen again, with memory always ready.
  task automatic measure(input logic [5:0] op, input logic jv, output int n,
                         output logic sreg, output logic smem);
    n = 0; sreg = 1'b0; smem = 1'b0;
    opcode = op; jr = jv; memReady = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      if (n > 0 && memRead && !iorD) break;
      if (regWrite) sreg = 1'b1;
      if (memWrite) smem = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    memReady = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int         n, mw;
    logic       sreg, smem;
    logic [5:0] ops[9];
    logic [5:0] op;
    ctl_t       c;

    tbl[0]  = '{"jr",   R,    1'b1, 3, 1'b0, 1'b0};
    tbl[1]  = '{"beq",  BEQ,  1'b0, 3, 1'b0, 1'b0};
    tbl[2]  = '{"bne",  BNE,  1'b0, 3, 1'b0, 1'b0};
    tbl[3]  = '{"j",    J,    1'b0, 3, 1'b0, 1'b0};
    tbl[4]  = '{"jal",  JAL,  1'b0, 3, 1'b1, 1'b0};
    tbl[5]  = '{"rtyp", R,    1'b0, 4, 1'b1, 1'b0};
    tbl[6]  = '{"addi", ADDI, 1'b0, 4, 1'b1, 1'b0};
    tbl[7]  = '{"andi", ANDI, 1'b0, 4, 1'b1, 1'b0};
    tbl[8]  = '{"sw",   SW,   1'b0, 4, 1'b0, 1'b1};
    tbl[9]  = '{"lw",   LW,   1'b0, 5, 1'b1, 1'b0};
    tbl[10] = '{"ill",  6'h3f, 1'b0, 2, 1'b0, 1'b0};
    ops = '{R, LW, SW, BEQ, BNE, J, JAL, ADDI, ANDI};

    rst = 1'b0; opcode = LW; jr = 1'b1; memReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctl("reset_outputs", act, fetch_ctl(1'b0));
    #1 rst = 1'b1; memReady = 1'b0; jr = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      measure(tbl[i].op, tbl[i].jv, n, sreg, smem);
      chk_int({tbl[i].nm, " cycles"}, n, tbl[i].cyc);
      chk_int({tbl[i].nm, " regWrite_seen"}, int'(sreg), int'(tbl[i].wreg));
      chk_int({tbl[i].nm, " memWrite_seen"}, int'(smem), int'(tbl[i].wmem));
    end

    build(SW, 1'b0, 0, 3);
    run_plan("sw_stall", SW, mw);
    chk_int("sw_stall memWrite_cycles", mw, 4);

    build(LW, 1'b0, 0, 0);
    run_plan("lw_seq", LW, mw);
    build(R, 1'b1, 0, 0);
    run_plan("jr_seq", R, mw);
    build(BNE, 1'b0, 1, 0);
    run_plan("bne_seq", BNE, mw);
    build(6'h3f, 1'b0, 0, 0);
    run_plan("illegal_seq", 6'h3f, mw);

    opcode = LW; memReady = 1'b1; jr = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0;
    @(negedge clk);
    c = '0; c.memRead = 1'b1; c.iorD = 1'b1;
    chk_ctl("midrd in_MEM_RD", act, c);
    #2 rst = 1'b0; memReady = 1'b1;
    #1 chk_ctl("midrd async_reset", act, fetch_ctl(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk_ctl("midrd held_reset", act, fetch_ctl(1'b0));
    #1 rst = 1'b1;
    #1 chk_ctl("midrd first_fetch", act, fetch_ctl(1'b1));
    @(posedge clk); #1;
    measure(LW, 1'b0, n, sreg, smem);
    chk_int("midrd lw_rest_cycles", n, 4);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      build(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan($sformatf("rnd%0d op%b", t, op), op, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
